// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol codes, unit multipliers and keyer FSM states.
// The dit/dah decoder uses the same symbol codes.
package morse_pkg;

  localparam logic [2:0] SYM_NONE = 3'd0;
  localparam logic [2:0] SYM_DIT  = 3'd1;
  localparam logic [2:0] SYM_DAH  = 3'd2;
  localparam logic [2:0] SYM_LGAP = 3'd3;
  localparam logic [2:0] SYM_WGAP = 3'd4;

  localparam int DAH_UNITS      = 3;
  localparam int ELEM_GAP_UNITS = 1;
  localparam int LGAP_EXTRA     = 2;
  localparam int WGAP_EXTRA     = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

  function automatic logic sym_is_valid(input logic [2:0] sym);
    return (sym == SYM_DIT) || (sym == SYM_DAH) ||
           (sym == SYM_LGAP) || (sym == SYM_WGAP);
  endfunction

endpackage

// File: rtl/morse_symbol_fifo.sv
// Small symbol FIFO in front of the keyer FSM; pointers carry an extra wrap
// bit so full and empty can be told apart.
module morse_symbol_fifo
  import morse_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       bigclk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [2:0] din,
  input  logic       pop,
  output logic [2:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [2:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge bigclk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: turns dit/dah/gap symbol codes into a timed on/off key line.
// Optional input FIFO enabled by defining MORSE_KEYER_FIFO_EN.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT       = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       bigclk,
  input  logic       reset_n,
  input  logic [2:0] symbol,
  input  logic       valid,
  output logic       ready,
  output logic       signal,
  output logic       busy
);

  localparam int CW = $clog2(6 * UNIT) + 1;

  localparam logic [CW-1:0] DIT_CNT  = CW'(UNIT - 1);
  localparam logic [CW-1:0] DAH_CNT  = CW'(DAH_UNITS * UNIT - 1);
  localparam logic [CW-1:0] GAP_CNT  = CW'(ELEM_GAP_UNITS * UNIT - 1);
  localparam logic [CW-1:0] LGAP_CNT = CW'(LGAP_EXTRA * UNIT - 1);
  localparam logic [CW-1:0] WGAP_CNT = CW'(WGAP_EXTRA * UNIT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          fsm_ready;
  logic          take;
  logic [2:0]    next_sym;
  state_t        load_state;
  logic [CW-1:0] load_cnt;

  assign fsm_ready = (state == ST_IDLE) || (state == ST_SPACE && cnt == '0);

`ifdef MORSE_KEYER_FIFO_EN
  logic       fifo_full;
  logic       fifo_empty;
  logic [2:0] fifo_dout;

  morse_symbol_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .bigclk  (bigclk),
    .reset_n (reset_n),
    .push    (valid && sym_is_valid(symbol)),
    .din     (symbol),
    .pop     (take),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ready    = !fifo_full;
  assign take     = fsm_ready && !fifo_empty;
  assign next_sym = fifo_dout;
  assign busy     = (state != ST_IDLE) || !fifo_empty;
`else
  assign ready    = fsm_ready;
  assign take     = valid && fsm_ready;
  assign next_sym = symbol;
  assign busy     = (state != ST_IDLE);
`endif

  // Where a newly accepted symbol sends the FSM; invalid codes fall back to IDLE.
  always_comb begin
    load_state = ST_IDLE;
    load_cnt   = '0;
    case (next_sym)
      SYM_DIT:  begin load_state = ST_MARK;  load_cnt = DIT_CNT;  end
      SYM_DAH:  begin load_state = ST_MARK;  load_cnt = DAH_CNT;  end
      SYM_LGAP: begin load_state = ST_SPACE; load_cnt = LGAP_CNT; end
      SYM_WGAP: begin load_state = ST_SPACE; load_cnt = WGAP_CNT; end
      default:  begin load_state = ST_IDLE;  load_cnt = '0;       end
    endcase
  end

  always_ff @(posedge bigclk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      signal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            state  <= load_state;
            cnt    <= load_cnt;
            signal <= (load_state == ST_MARK);
          end
        end
        ST_MARK: begin
          if (cnt == '0) begin
            state  <= ST_SPACE;
            cnt    <= GAP_CNT;
            signal <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_SPACE: begin
          // A symbol taken on the last space cycle keys with no idle bubble.
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (take) begin
            state  <= load_state;
            cnt    <= load_cnt;
            signal <= (load_state == ST_MARK);
          end else begin
            state  <= ST_IDLE;
            signal <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          signal <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer: vector table on a UNIT=1 keyer plus
// hand sequences for UNIT=2 timing and (with MORSE_KEYER_FIFO_EN) the FIFO.
module tb_morse_keyer;
  import morse_pkg::*;

  logic       bigclk;
  logic       reset_n;
  logic [2:0] symbol;
  logic       valid;
  logic       ready1, signal1, busy1;
  logic       ready2, signal2, busy2;

  int num_compared;
  int num_mismatched;

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [2:0] sym;
    logic       chk_ready;
    logic       exp_ready;
    logic       exp_signal;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  morse_keyer #(.UNIT(1), .FIFO_DEPTH(4)) dut1 (
    .bigclk  (bigclk),
    .reset_n (reset_n),
    .symbol  (symbol),
    .valid   (valid),
    .ready   (ready1),
    .signal  (signal1),
    .busy    (busy1)
  );

  morse_keyer #(.UNIT(2), .FIFO_DEPTH(4)) dut2 (
    .bigclk  (bigclk),
    .reset_n (reset_n),
    .symbol  (symbol),
    .valid   (valid),
    .ready   (ready2),
    .signal  (signal2),
    .busy    (busy2)
  );

  initial bigclk = 1'b0;
  always #5 bigclk = ~bigclk;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic add_vec(input logic rst_n, input logic v, input logic [2:0] s,
                         input logic chk_r, input logic er, input logic es, input logic eb);
    vec_t t;
    t.rst_n = rst_n; t.valid = v; t.sym = s; t.chk_ready = chk_r;
    t.exp_ready = er; t.exp_signal = es; t.exp_busy = eb;
    vecs.push_back(t);
  endtask

  // Drive one vector at the falling edge, check ready before the rising edge
  // and the registered outputs just after it.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge bigclk);
    reset_n = v.rst_n;
    valid   = v.valid;
    symbol  = v.sym;
    #1;
    if (v.chk_ready) checkOutput($sformatf("vec%0d_ready", idx), ready1, v.exp_ready);
    @(posedge bigclk);
    #1;
    checkOutput($sformatf("vec%0d_signal", idx), signal1, v.exp_signal);
    checkOutput($sformatf("vec%0d_busy", idx), busy1, v.exp_busy);
  endtask

  task automatic do_reset();
    @(negedge bigclk);
    reset_n = 1'b0;
    valid   = 1'b0;
    symbol  = SYM_NONE;
    @(negedge bigclk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [2:0] seq[$];
    int         idx;
    logic       took;
    logic       exp_sig;

    num_compared   = 0;
    num_mismatched = 0;
    reset_n = 1'b0;
    valid   = 1'b0;
    symbol  = SYM_NONE;

`ifndef MORSE_KEYER_FIFO_EN
    // rst_n, valid, symbol, chk_ready, exp_ready, exp_signal, exp_busy
    add_vec(0, 0, SYM_NONE, 0, 0, 0, 0);
    // dit, dit with valid held
    add_vec(1, 1, SYM_DIT,  1, 1, 1, 1);
    add_vec(1, 1, SYM_DIT,  1, 0, 0, 1);
    add_vec(1, 1, SYM_DIT,  1, 1, 1, 1);
    add_vec(1, 0, SYM_NONE, 1, 0, 0, 1);
    add_vec(1, 0, SYM_NONE, 1, 1, 0, 0);
    // dah, letter gap, dit back-to-back
    add_vec(1, 1, SYM_DAH,  1, 1, 1, 1);
    add_vec(1, 1, SYM_LGAP, 1, 0, 1, 1);
    add_vec(1, 1, SYM_LGAP, 1, 0, 1, 1);
    add_vec(1, 1, SYM_LGAP, 1, 0, 0, 1);
    add_vec(1, 1, SYM_LGAP, 1, 1, 0, 1);
    add_vec(1, 1, SYM_DIT,  1, 0, 0, 1);
    add_vec(1, 1, SYM_DIT,  1, 1, 1, 1);
    add_vec(1, 0, SYM_NONE, 1, 0, 0, 1);
    add_vec(1, 0, SYM_NONE, 1, 1, 0, 0);
    // invalid code is swallowed, following dit keys normally
    add_vec(1, 1, 3'b111,   1, 1, 0, 0);
    add_vec(1, 1, SYM_DIT,  1, 1, 1, 1);
    add_vec(1, 0, SYM_NONE, 1, 0, 0, 1);
    add_vec(1, 0, SYM_NONE, 1, 1, 0, 0);
    // reset on the second cycle of a dah
    add_vec(1, 1, SYM_DAH,  1, 1, 1, 1);
    add_vec(1, 0, SYM_NONE, 1, 0, 1, 1);
    add_vec(0, 0, SYM_NONE, 1, 0, 0, 0);
    add_vec(1, 0, SYM_NONE, 1, 1, 0, 0);
    add_vec(1, 0, SYM_NONE, 1, 1, 0, 0);

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // UNIT=2: word gap then dah -> 12 space, 6 mark, 2 space, idle
    do_reset();
    seq = '{SYM_WGAP, SYM_DAH};
    idx = 0;
    for (int e = 1; e <= 21; e++) begin
      @(negedge bigclk);
      if (idx < seq.size()) begin
        valid  = 1'b1;
        symbol = seq[idx];
      end else begin
        valid  = 1'b0;
        symbol = SYM_NONE;
      end
      #1;
      took = valid && ready2;
      @(posedge bigclk);
      #1;
      if (took) idx++;
      exp_sig = (e >= 13 && e <= 18);
      checkOutput($sformatf("unit2_edge%0d_signal", e), signal2, exp_sig);
    end
    checkOutput("unit2_busy_end", busy2, 1'b0);
    checkOutput("unit2_all_consumed", (idx == 2), 1'b1);
`else
    begin
      logic exp_pat[14];
      logic exp_rdy[7];
      exp_pat = '{1,0,1,1,1,0,1,0,1,1,1,0,1,0};
      exp_rdy = '{1,1,1,1,1,0,1};

      do_reset();
      #1;
      checkOutput("fifo_reset_ready", ready1, 1'b1);
      checkOutput("fifo_reset_busy", busy1, 1'b0);

      // dit dah dit dah dit pushed back-to-back; keying starts 2 edges after first push
      seq = '{SYM_DIT, SYM_DAH, SYM_DIT, SYM_DAH, SYM_DIT};
      idx = 0;
      for (int e = 1; e <= 16; e++) begin
        @(negedge bigclk);
        if (idx < seq.size()) begin
          valid  = 1'b1;
          symbol = seq[idx];
        end else begin
          valid  = 1'b0;
          symbol = SYM_NONE;
        end
        #1;
        took = valid && ready1;
        @(posedge bigclk);
        #1;
        if (took) idx++;
        exp_sig = (e >= 2 && e <= 15) ? exp_pat[e-2] : 1'b0;
        checkOutput($sformatf("fifo_edge%0d_signal", e), signal1, exp_sig);
      end
      checkOutput("fifo_busy_end", busy1, 1'b0);

      // six dahs: the FIFO fills and ready drops for one cycle
      do_reset();
      for (int e = 1; e <= 7; e++) begin
        @(negedge bigclk);
        valid  = 1'b1;
        symbol = SYM_DAH;
        #1;
        checkOutput($sformatf("fifo_full_edge%0d_ready", e), ready1, exp_rdy[e-1]);
        @(posedge bigclk);
      end
      @(negedge bigclk);
      valid = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
